// File: rtl/pw_trig_pkg.sv
// Shared state encoding and default widths for the trigger sequencer.
package pw_trig_pkg;

  localparam int unsigned DEF_DELAY_WIDTH = 20;
  localparam int unsigned DEF_WIDTH_WIDTH = 17;
  localparam int unsigned DEF_COUNT_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    DELAY = 3'd2,
    PULSE = 3'd3,
    GAP   = 3'd4,
    DONE  = 3'd5
  } pw_state_e;

endpackage

// File: rtl/pw_trigger_sequencer_down_counter.sv
// Loadable down counter that stops at zero; load has priority over enable.
module pw_down_counter #(
  parameter int unsigned pW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic [pW-1:0] i_load_val,
  input  logic          i_en,
  output logic          o_zero
);

  logic [pW-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - pW'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/pw_trigger_sequencer.sv
// Arms the pattern matcher, then turns each match into a delayed train of
// registered trigger pulses of programmable width, gap and count.
module pw_trigger_sequencer
  import pw_trig_pkg::*;
#(
  parameter int unsigned pDELAY_WIDTH = DEF_DELAY_WIDTH,
  parameter int unsigned pWIDTH_WIDTH = DEF_WIDTH_WIDTH,
  parameter int unsigned pCOUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic                    fe_clk,
  input  logic                    reset_n_i,
  input  logic                    I_arm,
  input  logic                    I_match_trigger,
  input  logic [pDELAY_WIDTH-1:0] I_delay,
  input  logic [pWIDTH_WIDTH-1:0] I_width,
  input  logic [pWIDTH_WIDTH-1:0] I_gap,
  input  logic [pCOUNT_WIDTH-1:0] I_num_triggers,
  output logic                    O_arm_matcher,
  output logic                    O_trigger,
  output logic                    O_armed,
  output logic                    O_done,
  output logic [pCOUNT_WIDTH-1:0] O_triggers_fired
);

  pw_state_e r_state;
  pw_state_e w_next_state;

  logic                    r_arm;
  logic                    w_arm_rise;
  logic                    r_trigger;
  logic [pDELAY_WIDTH-1:0] r_delay;
  logic [pWIDTH_WIDTH-1:0] r_width;
  logic [pWIDTH_WIDTH-1:0] r_gap;
  logic [pCOUNT_WIDTH-1:0] r_num;
  logic [pCOUNT_WIDTH-1:0] r_fired;

  logic                    w_dly_load;
  logic                    w_dly_en;
  logic                    w_dly_zero;
  logic                    w_ph_load;
  logic [pWIDTH_WIDTH-1:0] w_ph_val;
  logic                    w_ph_en;
  logic                    w_ph_zero;
  logic                    w_cnt_load;
  logic                    w_cnt_en;
  logic                    w_cnt_zero;
  logic                    w_fire;

  assign w_arm_rise = I_arm & ~r_arm;

  always_ff @(posedge fe_clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_arm <= 1'b0;
    end else begin
      r_arm <= I_arm;
    end
  end

  // Zero width/gap/count are stored as 1 so the counters can always load value-1.
  always_ff @(posedge fe_clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_delay <= '0;
      r_width <= '0;
      r_gap   <= '0;
      r_num   <= '0;
    end else if (w_arm_rise) begin
      r_delay <= I_delay;
      r_width <= (I_width == '0)        ? pWIDTH_WIDTH'(1) : I_width;
      r_gap   <= (I_gap == '0)          ? pWIDTH_WIDTH'(1) : I_gap;
      r_num   <= (I_num_triggers == '0) ? pCOUNT_WIDTH'(1) : I_num_triggers;
    end
  end

  pw_down_counter #(.pW(pDELAY_WIDTH)) u_delay_cnt (
    .i_clk      (fe_clk),
    .i_rst_n    (reset_n_i),
    .i_load     (w_dly_load),
    .i_load_val (r_delay - pDELAY_WIDTH'(1)),
    .i_en       (w_dly_en),
    .o_zero     (w_dly_zero)
  );

  pw_down_counter #(.pW(pWIDTH_WIDTH)) u_phase_cnt (
    .i_clk      (fe_clk),
    .i_rst_n    (reset_n_i),
    .i_load     (w_ph_load),
    .i_load_val (w_ph_val),
    .i_en       (w_ph_en),
    .o_zero     (w_ph_zero)
  );

  pw_down_counter #(.pW(pCOUNT_WIDTH)) u_pulse_cnt (
    .i_clk      (fe_clk),
    .i_rst_n    (reset_n_i),
    .i_load     (w_cnt_load),
    .i_load_val (r_num - pCOUNT_WIDTH'(1)),
    .i_en       (w_cnt_en),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge fe_clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Counters hold value-1, so a zero flag marks the final cycle of each phase.
  always_comb begin
    w_next_state = r_state;
    w_dly_load   = 1'b0;
    w_dly_en     = 1'b0;
    w_ph_load    = 1'b0;
    w_ph_val     = r_width - pWIDTH_WIDTH'(1);
    w_ph_en      = 1'b0;
    w_cnt_load   = 1'b0;
    w_cnt_en     = 1'b0;
    w_fire       = 1'b0;
    if ((r_state != IDLE) && !I_arm) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_arm_rise) w_next_state = ARMED;
        end
        ARMED: begin
          if (I_match_trigger) begin
            w_cnt_load = 1'b1;
            if (r_delay == '0) begin
              w_next_state = PULSE;
              w_ph_load    = 1'b1;
            end else begin
              w_next_state = DELAY;
              w_dly_load   = 1'b1;
            end
          end
        end
        DELAY: begin
          if (w_dly_zero) begin
            w_next_state = PULSE;
            w_ph_load    = 1'b1;
          end else begin
            w_dly_en = 1'b1;
          end
        end
        PULSE: begin
          if (w_ph_zero) begin
            w_fire = 1'b1;
            if (w_cnt_zero) begin
              w_next_state = DONE;
            end else begin
              w_next_state = GAP;
              w_ph_load    = 1'b1;
              w_ph_val     = r_gap - pWIDTH_WIDTH'(1);
              w_cnt_en     = 1'b1;
            end
          end else begin
            w_ph_en = 1'b1;
          end
        end
        GAP: begin
          if (w_ph_zero) begin
            w_next_state = PULSE;
            w_ph_load    = 1'b1;
          end else begin
            w_ph_en = 1'b1;
          end
        end
        DONE: begin
          if (w_arm_rise) w_next_state = ARMED;
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge fe_clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_trigger <= 1'b0;
      r_fired   <= '0;
    end else begin
      r_trigger <= (w_next_state == PULSE);
      if (w_arm_rise) begin
        r_fired <= '0;
      end else if (w_fire && (r_fired != '1)) begin
        r_fired <= r_fired + pCOUNT_WIDTH'(1);
      end
    end
  end

  assign O_arm_matcher    = (r_state == ARMED);
  assign O_armed          = (r_state == ARMED) || (r_state == DELAY) ||
                            (r_state == PULSE) || (r_state == GAP);
  assign O_done           = (r_state == DONE);
  assign O_trigger        = r_trigger;
  assign O_triggers_fired = r_fired;

endmodule

// File: doc/pw_trigger_sequencer.md
Name: pw_trigger_sequencer

Overview:
Sequences the pattern matcher and shapes its output into the external trigger. It arms the matcher on a register-block arm request and waits for the match pulse. It then applies a programmable delay and emits a programmable train of pulses, each of programmable width and separated by a programmable gap. It sits in the fe_clk domain between the pattern matcher and the trigger output pin logic.

Parameters:
pDELAY_WIDTH, 20, width of delay-count configuration and counter
pWIDTH_WIDTH, 17, width of pulse-width and gap configuration and counters
pCOUNT_WIDTH, 8, width of pulse-count configuration and fired counter

Ports:
fe_clk  input  1  sole clock; all logic on rising edge
reset_n_i  input  1  asynchronous, active-low reset
I_arm  input  1  arm level from register block, already synchronised to fe_clk
I_match_trigger  input  1  one-cycle match pulse from pattern matcher
I_delay  input  pDELAY_WIDTH  cycles from match to first pulse rising edge, minus 1
I_width  input  pWIDTH_WIDTH  pulse high time in cycles; 0 treated as 1
I_gap  input  pWIDTH_WIDTH  low time between pulses in cycles; 0 treated as 1
I_num_triggers  input  pCOUNT_WIDTH  pulses per match; 0 treated as 1
O_arm_matcher  output  1  arm to pattern matcher; high only in ARMED
O_trigger  output  1  registered trigger output
O_armed  output  1  high in ARMED, DELAY, PULSE, GAP
O_done  output  1  high in DONE
O_triggers_fired  output  pCOUNT_WIDTH  pulses emitted since last arm

Behaviour:
- Reset (asynchronous, reset_n_i low): state IDLE; all outputs 0; all counters 0; arm_r 0.
- arm_r is a registered copy of I_arm. arm_rise = I_arm & !arm_r.
- Config latch: I_delay, I_width, I_gap and I_num_triggers are captured into internal registers on arm_rise. The 0→1 substitution is applied at latch time. Config changes while armed have no effect.
- States:
  - IDLE: on arm_rise → ARMED; O_triggers_fired cleared.
  - ARMED: on I_match_trigger → DELAY with delay counter loaded with latched delay. If latched delay is 0 → PULSE directly.
  - DELAY: count down; at 0 → PULSE.
  - PULSE: O_trigger high for latched width cycles. On the last cycle O_triggers_fired increments. If this was the last pulse → DONE, else → GAP.
  - GAP: O_trigger low for latched gap cycles, then → PULSE.
  - DONE: hold. arm_rise → ARMED, with config re-latched and the fired counter cleared.
- Timing:
  - Match sampled high at cycle T with delay d: O_trigger is high from cycle T+1+d (d=0 gives 1-cycle latency).
  - O_trigger stays high exactly w cycles, then is low exactly g cycles before the next pulse.
  - O_trigger is driven from a flop, never combinationally.
- Disarm: I_arm low in any state other than IDLE → IDLE on the next edge. O_trigger is forced low on that same edge even mid-pulse. O_triggers_fired holds its value.
- Arm and disarm are level/edge based. A held-high I_arm in DONE does not re-arm; a fresh rising edge is required.
- I_match_trigger outside ARMED is ignored, including a second match during DELAY, PULSE or GAP. No queuing.
- Simultaneous events:
  - arm_rise and I_match_trigger in the same IDLE cycle: the match is ignored.
  - I_arm falling in the same cycle as I_match_trigger in ARMED: disarm wins.
- O_triggers_fired saturates at all-ones. It cannot wrap in practice because it is bounded by I_num_triggers.
- Counters are unsigned, sized exactly to their parameter. No arithmetic overflow is possible because all counters count down to 0.

Decomposition:
- Shared package pw_trig_pkg:
  - state enum localparams: IDLE=3'd0, ARMED=3'd1, DELAY=3'd2, PULSE=3'd3, GAP=3'd4, DONE=3'd5
  - default parameter values
- One natural sub-module, pw_down_counter: a loadable down counter with load, enable and zero flag, parameterised width. It is instantiated for delay, width/gap (shared, since the two phases are mutually exclusive) and the pulse count.
- The FSM stays in the top module.

Test Plan:
- Basic: arm, delay=0, width=1, num=1, match at cycle T → O_trigger high only at T+1; O_done high from T+2; O_triggers_fired=1.
- Delay/width: delay=10, width=5, match at T → O_trigger high on cycles T+11..T+15 inclusive, low otherwise; O_arm_matcher low from T+1.
- Train: num=3, width=2, gap=4 → pulses at T+1..T+2, T+7..T+8, T+13..T+14; O_triggers_fired steps 1,2,3; then DONE.
- Zero-substitution: width=0, gap=0, num=0 → exactly one 1-cycle pulse; second I_match_trigger 3 cycles later is ignored.
- Disarm mid-pulse: width=100, drop I_arm at pulse cycle 20 → O_trigger low next edge, state IDLE, O_triggers_fired=0. Re-arm with config change → new config used.
- Async reset asserted mid-DELAY (not clock aligned) → all outputs 0 immediately. Held-high I_arm after reset release re-arms only after arm_r samples it (one rising-edge detection).
